// File: rtl/microwave_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_ctrl
//
// Cooking-sequence controller for a three-digit BCD down-counting timer chain
// (0-999 s). Collects keypad digits into a BCD entry register, loads the
// entry into the chain, gates the chain's count enable from a 1 Hz tick,
// drives the magnetron, and handles the door interlock, pause/resume, cancel
// and the end-of-cook beep.
//
// Ports
//   clk          in   system clock, rising edge
//   clr          in   asynchronous active-high reset
//   tick         in   one-cycle 1 Hz strobe
//   key_valid    in   one-cycle keypad strobe
//   key_digit    in   [3:0] keypad digit, values > 9 ignored
//   start, stop  in   one-cycle button strobes
//   door_closed  in   level, 1 = door closed
//   timer_zero   in   all three chain digits are zero
//   tmr_in       out  [11:0] BCD load value {hundreds, tens, units}
//   tmr_load_n   out  active-low synchronous load to the chain
//   tmr_clr_n    out  active-low clear pulse to the chain
//   tmr_en       out  count enable to the units digit
//   mag_on       out  magnetron enable
//   beep         out  completion buzzer
//   state        out  [2:0] IDLE=0, SET=1, LOAD=2, COOK=3, PAUSE=4, DONE=5
// -----------------------------------------------------------------------------
module microwave_ctrl #(
   parameter logic [11:0] QUICK_START = 12'h030,
   parameter int          BEEP_TICKS  = 3
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        tick,
   input  logic        key_valid,
   input  logic [3:0]  key_digit,
   input  logic        start,
   input  logic        stop,
   input  logic        door_closed,
   input  logic        timer_zero,
   output logic [11:0] tmr_in,
   output logic        tmr_load_n,
   output logic        tmr_clr_n,
   output logic        tmr_en,
   output logic        mag_on,
   output logic        beep,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET   = 3'd1,
      LOAD  = 3'd2,
      COOK  = 3'd3,
      PAUSE = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam int CW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

   state_t        st;
   logic [11:0]   entry;
   logic [CW-1:0] beep_cnt;
   logic          key_ok;

   assign key_ok = key_valid && (key_digit <= 4'd9);
   assign state  = st;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         st         <= IDLE;
         entry      <= '0;
         beep_cnt   <= '0;
         tmr_in     <= '0;
         tmr_load_n <= 1'b1;
         tmr_clr_n  <= 1'b1;
         tmr_en     <= 1'b0;
         mag_on     <= 1'b0;
         beep       <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults first; any branch below that drives a
         // strobe low/high overrides it, so each strobe lasts exactly one cycle.
         tmr_load_n <= 1'b1;
         tmr_clr_n  <= 1'b1;
         tmr_en     <= 1'b0;

         case (st)
            IDLE: begin
               // stop in IDLE has top priority but no effect
               if (!stop) begin
                  if (start && door_closed) begin
                     entry      <= QUICK_START;
                     tmr_in     <= QUICK_START;
                     tmr_load_n <= 1'b0;
                     st         <= LOAD;
                  end else if (key_ok) begin
                     entry <= {entry[7:0], key_digit};
                     st    <= SET;
                  end
               end
            end

            SET: begin
               if (stop) begin
                  entry <= '0;
                  st    <= IDLE;
               end else if (start && door_closed && (entry != 12'h000)) begin
                  tmr_in     <= entry;
                  tmr_load_n <= 1'b0;
                  st         <= LOAD;
               end else if (key_ok) begin
                  entry <= {entry[7:0], key_digit};
               end
            end

            // Chain captures tmr_in on this edge; cooking starts with it.
            LOAD: begin
               mag_on <= 1'b1;
               st     <= COOK;
            end

            COOK: begin
               if (stop || !door_closed) begin
                  mag_on <= 1'b0;
                  st     <= PAUSE;
               end else if (timer_zero) begin
                  // A tick in the same cycle is deliberately dropped here.
                  mag_on   <= 1'b0;
                  beep     <= 1'b1;
                  beep_cnt <= '0;
                  st       <= DONE;
               end else if (tick) begin
                  tmr_en <= 1'b1;
               end
            end

            PAUSE: begin
               if (stop) begin
                  entry     <= '0;
                  tmr_clr_n <= 1'b0;
                  st        <= IDLE;
               end else if (start && door_closed) begin
                  // Resume from the held chain value; no reload.
                  mag_on <= 1'b1;
                  st     <= COOK;
               end
            end

            DONE: begin
               if (stop || !door_closed) begin
                  beep  <= 1'b0;
                  entry <= '0;
                  st    <= IDLE;
               end else if (key_ok) begin
                  beep  <= 1'b0;
                  entry <= {8'h00, key_digit};
                  st    <= SET;
               end else if (tick && beep) begin
                  beep_cnt <= beep_cnt + 1'b1;
                  if (beep_cnt == CW'(BEEP_TICKS - 1)) beep <= 1'b0;
               end
            end

            default: begin
               mag_on <= 1'b0;
               beep   <= 1'b0;
               st     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/microwave_ctrl.md
# microwave_ctrl

Cooking-sequence controller for the microwave timer datapath: three cascaded mod-10 down-counter digits (units, tens, hundreds of seconds, 0–999 s). Collects keypad digits and loads them into the timer chain. Gates the count enable from a 1 Hz tick strobe and drives the magnetron enable. Handles door interlock, pause, resume, cancel and the end-of-cook beep.

## Interface
- QUICK_START, 12'h030, BCD value loaded by start from IDLE (30 s).
- BEEP_TICKS, 3, number of ticks beep stays high after completion.
- clk  in  1  system clock, all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle 1 Hz strobe.
- key_valid  in  1  one-cycle keypad strobe.
- key_digit  in  4  keypad digit; values > 9 are ignored.
- start, stop  in  1  one-cycle button strobes.
- door_closed  in  1  level, 1 = door closed.
- timer_zero  in  1  AND of the three digit zero flags.
- tmr_in  out  12  BCD load value {hundreds, tens, units}.
- tmr_load_n  out  1  active-low synchronous load to the chain.
- tmr_clr_n  out  1  active-low clear pulse to the chain.
- tmr_en  out  1  count enable to the units digit.
- mag_on  out  1  magnetron enable.
- beep  out  1  completion buzzer.
- state  out  3  IDLE=0, SET=1, LOAD=2, COOK=3, PAUSE=4, DONE=5.

## Operation
- All outputs are registered.
- Reset values: state=IDLE, entry=0, tmr_in=0, tmr_load_n=1, tmr_clr_n=1, tmr_en=0, mag_on=0, beep=0.
- Entry register: 12-bit BCD.
  - A valid key (digit ≤ 9) in IDLE or SET shifts left: {d1, d0, key}. The state becomes SET.
  - A valid key in DONE loads entry={0, 0, key} and moves to SET.
  - Keys are ignored in LOAD, COOK and PAUSE.
- start, only when door_closed=1:
  - In IDLE: entry←QUICK_START, then go to LOAD.
  - In SET with entry≠0: go to LOAD.
  - In SET with entry=0: ignored.
- LOAD: tmr_in=entry and tmr_load_n=0 for exactly one cycle, then COOK.
- COOK: mag_on=1. Each tick with door_closed=1, stop=0 and timer_zero=0 produces tmr_en=1 for exactly one cycle.
- COOK exits:
  - timer_zero=1 → DONE.
  - door_closed=0 or stop → PAUSE.
- PAUSE: mag_on=0 and tmr_en=0; the timer value is held.
  - start with door_closed=1 → COOK, no reload.
  - stop → IDLE, with tmr_clr_n=0 for one cycle and entry cleared.
- stop in SET → IDLE with entry cleared. stop in IDLE does nothing.
- DONE: mag_on=0 and beep=1 until BEEP_TICKS ticks have elapsed, then beep=0.
  - stop or a door opening → IDLE, beep=0, entry cleared.
  - A key → SET.
- Priority within one cycle: clr > stop > door open > timer_zero > tick > start > key.

## Timing
- Key strobe at edge N: entry and state update at N+1.
- start in SET at edge N:
  - state=LOAD and tmr_load_n=0 at N+1.
  - state=COOK, mag_on=1, tmr_load_n=1 at N+2.
- tick at edge N in COOK: tmr_en=1 during N+1 only. The chain decrements at edge N+2.
- timer_zero first high in COOK at N: state=DONE, mag_on=0, beep=1 at N+1.
- A tick coinciding with timer_zero produces no tmr_en.
- Door opening during the cycle tmr_en is already high does not cancel that decrement; the next tick is blocked.
- Reset asserted mid-cook forces all outputs to their reset values immediately, without waiting for a clock edge. The timer chain contents are not touched.

## Test plan
- Keys 1, 2, 0 then start, door closed:
  - entry=12'h120; one LOAD cycle with tmr_in=12'h120 and tmr_load_n=0.
  - mag_on for 120 ticks, then DONE.
  - beep high for exactly 3 ticks, then low.
- start in IDLE → tmr_in=12'h030 loaded; DONE after 30 ticks.
- Cooking at 12'h045:
  - Open the door after 5 ticks → PAUSE, mag_on=0, no tmr_en during 3 further ticks.
  - Close the door and press start → COOK resumes from 40 with no reload.
- PAUSE then stop:
  - tmr_clr_n low for one cycle; state=IDLE, entry=0.
- Boundary cases:
  - start with entry=0 → state stays SET.
  - start with door open → ignored.
  - key_digit=4'hB → ignored.
  - stop and start in the same cycle while in SET → IDLE.
- Reset asserted mid-COOK → mag_on=0 and state=IDLE without a clock edge. Deassert, then quick-start → a normal 30 s cycle.
